// File: rtl/delay_meas.sv
// Round-trip latency meter: emits a probe pulse, counts clk cycles until the echo returns.
// Latency: done pulses one cycle after the echo is seen (or the wait window runs out).
// Flow: start is ignored while a run is busy or finishing; it is never queued.
module delay_meas #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000,
  parameter int PULSE_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr_stats,
  input  logic                 echo_in,
  output logic                 probe_out,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic                 stuck_err,
  output logic [CNT_WIDTH-1:0] delay_cnt,
  output logic [CNT_WIDTH-1:0] min_cnt,
  output logic [CNT_WIDTH-1:0] max_cnt,
  output logic [CNT_WIDTH-1:0] meas_count
);

  localparam logic [CNT_WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [CNT_WIDTH-1:0] ZERO       = '0;
  localparam logic [CNT_WIDTH-1:0] ONE        = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  // The wait window covers cycles 0 .. TIMEOUT-1, so a run that is still
  // silent on cycle TIMEOUT-1 aborts and its done lands on cycle TIMEOUT.
  localparam logic [CNT_WIDTH-1:0] LAST_WAIT  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_PROBE = CNT_WIDTH'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 running;
  logic                 echo_hit;

  // Echo is watched from the first probe cycle onwards, including while the probe is still high.
  always_comb begin
    running  = (state == S_PROBE) || (state == S_WAIT);
    echo_hit = running && echo_in;
  end

  // Measurement FSM; every output it drives is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= ZERO;
      probe_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      stuck_err   <= 1'b0;
      delay_cnt   <= ZERO;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            if (echo_in) begin
              // Echo already high: any latency we measured would be bogus, so no probe goes out.
              stuck_err <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              stuck_err <= 1'b0;
              probe_out <= 1'b1;
              cnt       <= ZERO;
              state     <= S_PROBE;
            end
          end
        end

        S_PROBE, S_WAIT: begin
          cnt <= cnt + ONE;
          if (echo_in) begin
            delay_cnt <= cnt;
            probe_out <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (cnt == LAST_WAIT) begin
            timeout_err <= 1'b1;
            probe_out   <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else if ((state == S_PROBE) && (cnt == LAST_PROBE)) begin
            probe_out <= 1'b0;
            state     <= S_WAIT;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          probe_out <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Statistics; a clear that lands on a capture cycle keeps just that one sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_cnt    <= ALL_ONES;
      max_cnt    <= ZERO;
      meas_count <= ZERO;
    end else if (clr_stats) begin
      if (echo_hit) begin
        min_cnt    <= cnt;
        max_cnt    <= cnt;
        meas_count <= ONE;
      end else begin
        min_cnt    <= ALL_ONES;
        max_cnt    <= ZERO;
        meas_count <= ZERO;
      end
    end else if (echo_hit) begin
      if (cnt < min_cnt) begin
        min_cnt <= cnt;
      end
      if (cnt > max_cnt) begin
        max_cnt <= cnt;
      end
      if (meas_count != ALL_ONES) begin
        meas_count <= meas_count + ONE;
      end
    end
  end

endmodule

// File: tb/tb_delay_meas.sv
// Directed bench for delay_meas: echo is modelled as a delayed copy of probe_out.
module tb_delay_meas;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clr_stats = 1'b0;
  logic         echo_in;
  logic         probe_out, busy, done, timeout_err, stuck_err;
  logic [W-1:0] delay_cnt, min_cnt, max_cnt, meas_count;

  // echo_mode: 0 = tied low, 1 = tied high, 2 = probe delayed echo_dly cycles, 3 = combinational loopback
  int           echo_mode = 0;
  int           echo_dly = 1;
  logic [15:0]  sh = '0;

  int checks = 0;
  int errors = 0;
  int done_at, probe_hi, extra;

  delay_meas #(.CNT_WIDTH(W), .TIMEOUT(1000), .PULSE_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_stats(clr_stats), .echo_in(echo_in),
    .probe_out(probe_out), .busy(busy), .done(done), .timeout_err(timeout_err),
    .stuck_err(stuck_err), .delay_cnt(delay_cnt), .min_cnt(min_cnt), .max_cnt(max_cnt),
    .meas_count(meas_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sh <= {sh[14:0], probe_out};

  always_comb begin
    echo_in = 1'b0;
    case (echo_mode)
      1:       echo_in = 1'b1;
      2:       echo_in = sh[echo_dly-1];
      3:       echo_in = probe_out;
      default: echo_in = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Idle long enough to flush stale echo, pulse start, then track the run until done.
  // done_at is the cycle index of done, counting the first probe cycle as 0.
  task automatic run(output int d_at, output int p_hi);
    repeat (20) @(negedge clk);
    start = 1'b1;
    d_at = -1;
    p_hi = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      start = 1'b0;
      d_at++;
      if (probe_out) p_hi++;
      if (done) break;
    end
  endtask

  task automatic chk_stats(input string tag, input int d, input int mn, input int mx, input int n);
    chk({tag, ".delay"}, 32'(delay_cnt), d);
    chk({tag, ".min"}, 32'(min_cnt), mn);
    chk({tag, ".max"}, 32'(max_cnt), mx);
    chk({tag, ".count"}, 32'(meas_count), n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.probe", 32'(probe_out), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.timeout", 32'(timeout_err), 0);
    chk("rst.stuck", 32'(stuck_err), 0);
    chk_stats("rst", 0, 16'hffff, 0, 0);
    rst_n = 1'b1;

    // Single run, echo delayed 6 cycles.
    echo_mode = 2; echo_dly = 6;
    run(done_at, probe_hi);
    chk("d6.done_at", done_at, 7);
    chk("d6.probe_hi", probe_hi, 4);
    chk("d6.busy_in_done", 32'(busy), 1);
    chk_stats("d6", 6, 6, 6, 1);
    chk("d6.timeout", 32'(timeout_err), 0);
    chk("d6.stuck", 32'(stuck_err), 0);
    @(negedge clk);
    chk("d6.done_one_cycle", 32'(done), 0);
    chk("d6.busy_after", 32'(busy), 0);

    // Clear statistics; delay_cnt stays.
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk_stats("clr", 6, 16'hffff, 0, 0);

    // Successive runs 3, 9, 5.
    echo_dly = 3;
    run(done_at, probe_hi);
    chk("d3.done_at", done_at, 4);
    chk("d3.probe_hi", probe_hi, 4);
    echo_dly = 9;
    run(done_at, probe_hi);
    chk("d9.done_at", done_at, 10);
    echo_dly = 5;
    run(done_at, probe_hi);
    chk("d5.done_at", done_at, 6);
    chk_stats("seq", 5, 3, 9, 3);

    // Timeout: echo never comes back.
    echo_mode = 0;
    run(done_at, probe_hi);
    chk("to.done_at", done_at, 1000);
    chk("to.probe_hi", probe_hi, 4);
    chk("to.timeout", 32'(timeout_err), 1);
    chk("to.stuck", 32'(stuck_err), 0);
    chk_stats("to", 5, 3, 9, 3);

    // Stuck echo, plus a start during the done cycle that must be dropped.
    echo_mode = 1;
    run(done_at, probe_hi);
    chk("stk.done_at", done_at, 0);
    chk("stk.probe_hi", probe_hi, 0);
    chk("stk.stuck", 32'(stuck_err), 1);
    chk("stk.timeout", 32'(timeout_err), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    chk("stk.ignored_start", extra, 0);
    chk_stats("stk", 5, 3, 9, 3);

    // Combinational loopback.
    echo_mode = 3;
    run(done_at, probe_hi);
    chk("lb.done_at", done_at, 1);
    chk("lb.probe_hi", probe_hi, 1);
    chk("lb.stuck", 32'(stuck_err), 0);
    chk_stats("lb", 0, 0, 9, 4);

    // Loopback with clr_stats on the capture cycle: the clear keeps that sample.
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk("lbclr.done", 32'(done), 1);
    chk_stats("lbclr", 0, 0, 0, 1);

    // Asynchronous reset while waiting for an echo.
    echo_mode = 0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ar.busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.probe", 32'(probe_out), 0);
    chk("ar.busy", 32'(busy), 0);
    chk("ar.done", 32'(done), 0);
    chk_stats("ar", 0, 16'hffff, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("ar.no_done", extra, 0);

    // Normal measurement after reset.
    echo_mode = 2; echo_dly = 6;
    run(done_at, probe_hi);
    chk("post.done_at", done_at, 7);
    chk_stats("post", 6, 6, 6, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
